// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int ADDR_W          = 8;
  localparam int DATA_W          = 8;
  localparam int DEF_NUM_LINES   = 8;
  localparam int DEF_BLOCK_BYTES = 4;
  localparam int INDEX_W         = $clog2(DEF_NUM_LINES);
  localparam int OFFSET_W        = $clog2(DEF_BLOCK_BYTES);
  localparam int TAG_W           = ADDR_W - INDEX_W - OFFSET_W;
  localparam int STATS_W         = 16;

  typedef logic [STATS_W-1:0] dcache_stats_t;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    WB_GAP,
    ALLOC,
    ALLOC_GAP,
    UPDATE
  } dcache_state_e;
endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for the data cache: one byte write port, one
// tag write port, asynchronous read, valid/dirty cleared by asynchronous reset.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES   = DEF_NUM_LINES,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int TAG_BITS    = TAG_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [$clog2(NUM_LINES)-1:0]  rd_index,
  output logic                          rd_valid,
  output logic                          rd_dirty,
  output logic [TAG_BITS-1:0]           rd_tag,
  output logic [BLOCK_BYTES*DATA_W-1:0] rd_data,
  input  logic                          bw_en,
  input  logic [$clog2(NUM_LINES)-1:0]  bw_index,
  input  logic [$clog2(BLOCK_BYTES)-1:0] bw_offset,
  input  logic [DATA_W-1:0]             bw_data,
  input  logic                          bw_set_dirty,
  input  logic                          tw_en,
  input  logic [$clog2(NUM_LINES)-1:0]  tw_index,
  input  logic [TAG_BITS-1:0]           tw_tag
);
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]    data_mem [NUM_LINES][BLOCK_BYTES];

  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];
  assign rd_tag   = tag_mem[rd_index];

  for (genvar b = 0; b < BLOCK_BYTES; b++) begin : g_rd
    assign rd_data[b*DATA_W +: DATA_W] = data_mem[rd_index][b];
  end

  // A tag write marks a freshly refilled line: valid and clean.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (tw_en) begin
        valid[tw_index] <= 1'b1;
        dirty[tw_index] <= 1'b0;
      end
      if (bw_en && bw_set_dirty) dirty[bw_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (bw_en) data_mem[bw_index][bw_offset] <= bw_data;
    if (tw_en) tag_mem[tw_index] <= tw_tag;
  end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES   = DEF_NUM_LINES,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_address,
  output logic [7:0]  mem_writedata,
  input  logic [7:0]  mem_readdata,
  input  logic        mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
  localparam int INDEX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS;

  dcache_state_e state, state_next;
  logic [OFFSET_BITS-1:0] beat;
  logic                   req_held;
  logic [TAG_BITS-1:0]    miss_tag;
  logic [INDEX_BITS-1:0]  miss_index;

  logic [TAG_BITS-1:0]    addr_tag;
  logic [INDEX_BITS-1:0]  addr_index;
  logic [OFFSET_BITS-1:0] addr_offset;
  logic [INDEX_BITS-1:0]  line_index;
  logic                   line_valid, line_dirty;
  logic [TAG_BITS-1:0]    line_tag;
  logic [BLOCK_BYTES*DATA_W-1:0] line_data;

  logic                   req, hit, last_beat, beat_done;
  logic                   bw_en, bw_set_dirty, tw_en;
  logic [INDEX_BITS-1:0]  bw_index;
  logic [OFFSET_BITS-1:0] bw_offset;
  logic [DATA_W-1:0]      bw_data;

  assign {addr_tag, addr_index, addr_offset} = address;
  assign req        = read ^ write;
  // During a miss the array is addressed from the latched miss register.
  assign line_index = (state == IDLE) ? addr_index : miss_index;
  assign hit        = line_valid && (line_tag == addr_tag);
  assign readdata   = hit ? line_data[int'(addr_offset)*DATA_W +: DATA_W] : '0;
  assign last_beat  = (beat == OFFSET_BITS'(BLOCK_BYTES - 1));
  assign beat_done  = req_held && !mem_busywait;

  dcache_line_array #(
    .NUM_LINES  (NUM_LINES),
    .BLOCK_BYTES(BLOCK_BYTES),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .clock       (clock),
    .reset       (reset),
    .rd_index    (line_index),
    .rd_valid    (line_valid),
    .rd_dirty    (line_dirty),
    .rd_tag      (line_tag),
    .rd_data     (line_data),
    .bw_en       (bw_en),
    .bw_index    (bw_index),
    .bw_offset   (bw_offset),
    .bw_data     (bw_data),
    .bw_set_dirty(bw_set_dirty),
    .tw_en       (tw_en),
    .tw_index    (miss_index),
    .tw_tag      (miss_tag)
  );

  always_comb begin
    state_next    = state;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    bw_en         = 1'b0;
    bw_set_dirty  = 1'b0;
    bw_index      = addr_index;
    bw_offset     = addr_offset;
    bw_data       = writedata;
    tw_en         = 1'b0;
    case (state)
      IDLE: begin
        if (req && hit) begin
          bw_en        = write;
          bw_set_dirty = write;
        end else if (req) begin
          busywait   = 1'b1;
          state_next = (line_valid && line_dirty) ? WB : ALLOC;
        end
      end
      WB: begin
        busywait      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {line_tag, miss_index, beat};
        mem_writedata = line_data[int'(beat)*DATA_W +: DATA_W];
        if (beat_done) state_next = WB_GAP;
      end
      WB_GAP: begin
        busywait   = 1'b1;
        state_next = last_beat ? ALLOC : WB;
      end
      ALLOC: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {miss_tag, miss_index, beat};
        if (beat_done) begin
          bw_en      = 1'b1;
          bw_index   = miss_index;
          bw_offset  = beat;
          bw_data    = mem_readdata;
          state_next = ALLOC_GAP;
        end
      end
      ALLOC_GAP: begin
        busywait   = 1'b1;
        state_next = last_beat ? UPDATE : ALLOC;
      end
      UPDATE: begin
        busywait   = 1'b1;
        tw_en      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // req_held marks that the current beat's request has been up for a full cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat     <= '0;
      req_held <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE:              beat     <= '0;
        WB, ALLOC:         req_held <= !beat_done;
        WB_GAP, ALLOC_GAP: beat     <= last_beat ? '0 : beat + 1'b1;
        default:           req_held <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && req && !hit) begin
      miss_tag   <= addr_tag;
      miss_index <= addr_index;
    end
  end

`ifdef DCACHE_STATS_EN
  logic refill_done;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // The access that completes right after a refill is not a first-try hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count   <= '0;
      miss_count  <= '0;
      refill_done <= 1'b0;
    end else begin
      if (state == UPDATE) refill_done <= 1'b1;
      else if (state == IDLE) refill_done <= 1'b0;
      if (state == IDLE && req && hit && !refill_done) hit_count <= sat_inc(hit_count);
      if (state == IDLE && req && !hit) miss_count <= sat_inc(miss_count);
    end
  end
`endif
endmodule
